// File: rtl/ppt_cmd_uart_rx.sv
// Purpose: 8N1 serial command receiver. It oversamples rx, deserialises bytes LSB-first,
//          flags framing errors and decodes slide-control bytes into command strobes.
// Latency: strobes fire 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk cycles after the start-bit edge.
// Backpressure: none. Strobes are single-cycle, and data holds the last good byte until the next one.
// Ports:
//   clk, rst (async, active-high)    clock and reset
//   ena                              receiver enable; low forces IDLE and suppresses strobes
//   rx                               serial line, idles high, asynchronous to clk
//   data                             last good byte
//   data_valid, frame_err            per-frame result strobes
//   cmd_next, cmd_prev, cmd_blank    decoded command strobes, each paired with data_valid
//   busy                             high whenever the FSM is not IDLE
module ppt_cmd_uart_rx #(
   parameter int         CLKS_PER_BIT = 16,
   parameter logic [7:0] CMD_NEXT     = 8'h4E,
   parameter logic [7:0] CMD_PREV     = 8'h50,
   parameter logic [7:0] CMD_BLANK    = 8'h42
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       cmd_next,
   output logic       cmd_prev,
   output logic       cmd_blank,
   output logic       busy
);

   localparam int            TW        = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] tick, tick_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shift, shift_nxt;
   logic [7:0]    data_nxt;
   logic          dv_nxt, fe_nxt, cn_nxt, cp_nxt, cb_nxt;
   logic          rx_meta, rx_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // Both synchroniser flops reset high so the idle line never looks like a start bit.
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         state      <= S_IDLE;
         tick       <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         cmd_next   <= 1'b0;
         cmd_prev   <= 1'b0;
         cmd_blank  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_s       <= rx_meta;
         state      <= state_nxt;
         tick       <= tick_nxt;
         bit_idx    <= bit_nxt;
         shift      <= shift_nxt;
         data       <= data_nxt;
         data_valid <= dv_nxt;
         frame_err  <= fe_nxt;
         cmd_next   <= cn_nxt;
         cmd_prev   <= cp_nxt;
         cmd_blank  <= cb_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tick_nxt  = tick + 1'b1;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      data_nxt  = data;
      dv_nxt    = 1'b0;
      fe_nxt    = 1'b0;
      cn_nxt    = 1'b0;
      cp_nxt    = 1'b0;
      cb_nxt    = 1'b0;

      case (state)
         S_IDLE: begin
            tick_nxt = '0;
            if (!rx_s) state_nxt = S_START;
         end
         S_START: begin
            // Re-check the line at mid start bit; a high level here was a glitch.
            if (tick == TICK_HALF) begin
               tick_nxt  = '0;
               bit_nxt   = '0;
               state_nxt = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick == TICK_LAST) begin
               tick_nxt           = '0;
               shift_nxt[bit_idx] = rx_s;
               if (bit_idx == 3'd7) state_nxt = S_STOP;
               else                 bit_nxt   = bit_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (tick == TICK_LAST) begin
               tick_nxt = '0;
               if (rx_s) begin
                  data_nxt  = shift;
                  dv_nxt    = 1'b1;
                  cn_nxt    = (shift == CMD_NEXT);
                  cp_nxt    = (shift == CMD_PREV);
                  cb_nxt    = (shift == CMD_BLANK);
                  state_nxt = S_IDLE;
               end else begin
                  fe_nxt    = 1'b1;
                  state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // A line held low reports one framing error. Wait here until it returns high.
            tick_nxt = '0;
            if (rx_s) state_nxt = S_IDLE;
         end
         default: begin
            tick_nxt  = '0;
            state_nxt = S_IDLE;
         end
      endcase

      if (!ena) begin
         state_nxt = S_IDLE;
         tick_nxt  = '0;
         shift_nxt = shift;
         data_nxt  = data;
         dv_nxt    = 1'b0;
         fe_nxt    = 1'b0;
         cn_nxt    = 1'b0;
         cp_nxt    = 1'b0;
         cb_nxt    = 1'b0;
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ppt_cmd_uart_rx.sv
// Purpose: self-checking bench for ppt_cmd_uart_rx. A scoreboard queue holds the strobe
//          events expected for each frame driven. The monitor pops and compares them.
// Latency: frames are driven at 160 ns/bit against a 10 ns clock.
// Backpressure: not applicable.
module tb_ppt_cmd_uart_rx;

   localparam int BIT_NS = 160;

   logic       clk = 1'b0;
   logic       rst, ena, rx;
   logic [7:0] data;
   logic       data_valid, frame_err, cmd_next, cmd_prev, cmd_blank, busy;

   typedef struct packed {
      logic       dv;
      logic       fe;
      logic       cn;
      logic       cp;
      logic       cb;
      logic [7:0] d;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] last_good;
   int         total = 0;
   int         bad   = 0;
   time        last_strobe_t = 0;

   always #5 clk = ~clk;

   ppt_cmd_uart_rx #(.CLKS_PER_BIT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .rx        (rx),
      .data      (data),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .cmd_next  (cmd_next),
      .cmd_prev  (cmd_prev),
      .cmd_blank (cmd_blank),
      .busy      (busy)
   );

   // The expected event is built from the byte itself, not from the DUT.
   task automatic expect_frame(input logic [7:0] b, input logic stop_bit);
      ev_t e;
      e.dv = stop_bit;
      e.fe = !stop_bit;
      e.cn = stop_bit && (b == 8'h4E);
      e.cp = stop_bit && (b == 8'h50);
      e.cb = stop_bit && (b == 8'h42);
      if (stop_bit) last_good = b;
      e.d  = last_good;
      exp_q.push_back(e);
   endtask

   // Leaves rx at the stop-bit level when it returns.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(BIT_NS);
      end
      rx = stop_bit;
      #(BIT_NS);
   endtask

   task automatic monitor();
      ev_t obs, e;
      forever begin
         @(negedge clk);
         if (data_valid || frame_err || cmd_next || cmd_prev || cmd_blank) begin
            obs = '{data_valid, frame_err, cmd_next, cmd_prev, cmd_blank, data};
            last_strobe_t = $time;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_strobe got dv/fe/n/p/b/data=%h want none", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  bad++;
                  $display("FAIL strobe_event got=%h want=%h", obs, e);
               end
            end
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain pending=%0d want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ena = 1'b1; rx = 1'b1; last_good = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++;
      if ({data_valid, frame_err, cmd_next, cmd_prev, cmd_blank} !== 5'b0) begin
         bad++;
         $display("FAIL reset_strobes got=%b want=00000",
                  {data_valid, frame_err, cmd_next, cmd_prev, cmd_blank});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_next();
      time t_fall, dt;
      @(posedge clk); #2;
      t_fall = $time;
      expect_frame(8'h4E, 1'b1);
      send_frame(8'h4E, 1'b1);
      wait_drain("single_next");
      // Strobe should appear 154 cycles (2 + 8 + 144) after the falling edge, within one cycle.
      dt = last_strobe_t - t_fall;
      total++;
      if (dt < 1540 || dt > 1560) begin
         bad++;
         $display("FAIL latency got=%0t ns want 1540..1560", dt);
      end
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_frame got=%b want=0", busy); end
   endtask

   task automatic test_back_to_back();
      expect_frame(8'h50, 1'b1);
      expect_frame(8'h42, 1'b1);
      expect_frame(8'h41, 1'b1);
      send_frame(8'h50, 1'b1);
      send_frame(8'h42, 1'b1);
      send_frame(8'h41, 1'b1);
      wait_drain("back_to_back");
      total++;
      if (data !== 8'h41) begin bad++; $display("FAIL b2b_data got=%h want=41", data); end
   endtask

   task automatic test_frame_err();
      expect_frame(8'hA5, 1'b0);
      send_frame(8'hA5, 1'b0);
      #500;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL break_busy got=%b want=1", busy); end
      rx = 1'b1;
      wait_drain("frame_err");
      repeat (5) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL break_exit_busy got=%b want=0", busy); end
      total++;
      if (data !== 8'h41) begin bad++; $display("FAIL err_data_held got=%h want=41", data); end
      expect_frame(8'h5A, 1'b1);
      send_frame(8'h5A, 1'b1);
      wait_drain("after_break");
   endtask

   task automatic test_glitch();
      int n = 0;
      @(posedge clk); #2;
      rx = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 3) rx = 1'b1;
         if (busy) n++;
      end
      total++;
      if (n < 1 || n > 10) begin bad++; $display("FAIL glitch_busy_cycles got=%0d want 1..10", n); end
      total++;
      if (data !== 8'h5A) begin bad++; $display("FAIL glitch_data got=%h want=5A", data); end
   endtask

   task automatic test_reset_mid_frame();
      @(posedge clk); #2;
      fork
         send_frame(8'hAA, 1'b1);
         begin
            #(4 * BIT_NS + 80);
            rst = 1'b1;
            #1;
            total++;
            if (data !== 8'h00 || busy !== 1'b0 ||
                {data_valid, frame_err, cmd_next, cmd_prev, cmd_blank} !== 5'b0) begin
               bad++;
               $display("FAIL rst_mid_frame got data=%h busy=%b want data=00 busy=0", data, busy);
            end
         end
      join
      last_good = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      expect_frame(8'h55, 1'b1);
      send_frame(8'h55, 1'b1);
      wait_drain("after_rst");
   endtask

   task automatic test_ena_abort();
      @(posedge clk); #2;
      fork
         send_frame(8'h4E, 1'b1);
         begin
            #(6 * BIT_NS + 80);
            ena = 1'b0;
            @(posedge clk); #1;
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL ena_abort_busy got=%b want=0", busy); end
         end
      join
      repeat (5) @(negedge clk);
      total++;
      if (data !== 8'h55) begin bad++; $display("FAIL ena_abort_data got=%h want=55", data); end
      ena = 1'b1;
      repeat (5) @(negedge clk);
      expect_frame(8'h4E, 1'b1);
      send_frame(8'h4E, 1'b1);
      wait_drain("after_ena");
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; rx = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_single_next();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_reset_mid_frame();
      test_ena_abort();
      repeat (20) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
